// File: rtl/gray_to_bin_seq_pkg.sv
// Shared types and helpers for the sequential Gray-to-binary decoder.
// Holds the FSM state encoding and the bit-index width helper.
package gray_to_bin_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The index needs at least one bit, so a 1-bit word still gets a legal index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gray_to_bin_seq.sv
// Sequential Gray-to-binary decoder: accepts one Gray word, decodes it MSB-first
// one bit per clock with a running XOR, then holds the binary result until taken.
module gray_to_bin_seq
    import gray_to_bin_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] g,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] b
);

    localparam int IDX_W = idx_width(N);

    state_t             state_q, state_d;
    logic [N-1:0]       g_q, g_d;
    logic [N-1:0]       b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               acc_q, acc_d;
    logic               bit_val;

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        b_d       = b_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        bit_val   = g_q[idx_q] ^ acc_q;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    g_d     = g;
                    b_d     = '0;
                    idx_d   = IDX_W'(N - 1);
                    acc_d   = 1'b0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                b_d[idx_q] = bit_val;
                acc_d      = bit_val;
                if (idx_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            // The unused encoding falls back to IDLE instead of locking up.
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
        end
    end

    assign b = b_q;

endmodule
